// File: rtl/uart_rx_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_port                                                 |
// | Description : UART receiver feeding the MIPS pin/pin_valid input port.     |
// |               rxd -> 2-flop sync -> mid-bit sampler FSM -> byte hold reg.  |
// |               Single clock domain; baud timing from an internal counter.   |
// | Options     : UART_RX_PARITY_EN defined   -> 8E1 frames (even parity)      |
// |               UART_RX_PARITY_EN undefined -> 8N1 frames, no parity logic   |
// | Ports       : clk        in   system clock, rising edge                    |
// |               rst        in   asynchronous reset, active low               |
// |               rx_enable  in   1 = accept new frames                        |
// |               uart_rxd   in   asynchronous serial input                    |
// |               data_out   out  last good byte, held until the next one      |
// |               data_valid out  1-cycle pulse when data_out updates          |
// |               frame_err  out  1-cycle pulse on bad stop (or parity) bit    |
// |               rx_busy    out  high while the receiver is inside a frame    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_port #(
    parameter int   CLKS_PER_BIT = 5208,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_enable,
    input  logic       uart_rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd4;
`endif

    // After the last data bit the frame goes to the parity bit if present.
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_S_AFTER_DATA = c_S_PARITY;
`else
    localparam logic [2:0] c_S_AFTER_DATA = c_S_STOP;
`endif

    logic               r_rxd_meta;
    logic               r_rxd_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    // Cleared on a bad stop bit so a held-low (break) line cannot re-arm
    // the receiver until it has gone back to the idle level.
    logic               r_armed;

    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [3:0]         w_bit_next;
    logic [7:0]         w_shift_next;
    logic               w_armed_next;
    logic               w_load;
    logic               w_valid_next;
    logic               w_ferr_next;
    logic               w_frame_ok;

`ifdef UART_RX_PARITY_EN
    logic               r_par_err;
    logic               w_par_next;
    assign w_frame_ok = ~r_par_err;
`else
    assign w_frame_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxd_meta <= IDLE_LEVEL;
            r_rxd_s    <= IDLE_LEVEL;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_armed    <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_cnt_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_armed    <= w_armed_next;
            data_valid <= w_valid_next;
            frame_err  <= w_ferr_next;
            if (w_load) begin
                data_out <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_baud_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_armed_next = r_armed;
        w_load       = 1'b0;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_next   = r_par_err;
`endif

        case (r_state)
            c_S_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = '0;
                if (r_rxd_s == IDLE_LEVEL) begin
                    w_armed_next = 1'b1;
                end else if (rx_enable && r_armed) begin
                    w_state_next = c_S_START;
                end
            end

            c_S_START: begin
                if (r_baud_cnt == c_HALF_M1) begin
                    w_cnt_next = '0;
                    // A start bit that vanished by its centre is a glitch.
                    if (r_rxd_s != IDLE_LEVEL) begin
                        w_state_next = c_S_DATA;
`ifdef UART_RX_PARITY_EN
                        w_par_next   = 1'b0;
`endif
                    end else begin
                        w_state_next = c_S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_baud_cnt + 1'b1;
                end
            end

            c_S_DATA: begin
                if (r_baud_cnt == c_FULL_M1) begin
                    w_cnt_next   = '0;
                    // LSB arrives first: shift right, new bit enters at the top.
                    w_shift_next = {r_rxd_s, r_shift[7:1]};
                    if (r_bit_cnt == 4'd7) begin
                        w_bit_next   = '0;
                        w_state_next = c_S_AFTER_DATA;
                    end else begin
                        w_bit_next = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_baud_cnt + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            c_S_PARITY: begin
                if (r_baud_cnt == c_FULL_M1) begin
                    w_cnt_next   = '0;
                    // Even parity: data bits plus parity bit must XOR to zero.
                    w_par_next   = (^r_shift) ^ r_rxd_s;
                    w_state_next = c_S_STOP;
                end else begin
                    w_cnt_next = r_baud_cnt + 1'b1;
                end
            end
`endif

            c_S_STOP: begin
                if (r_baud_cnt == c_FULL_M1) begin
                    w_cnt_next   = '0;
                    w_state_next = c_S_IDLE;
                    if (r_rxd_s == IDLE_LEVEL) begin
                        if (w_frame_ok) begin
                            w_load       = 1'b1;
                            w_valid_next = 1'b1;
                        end else begin
                            w_ferr_next = 1'b1;
                        end
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_armed_next = 1'b0;
                    end
                end else begin
                    w_cnt_next = r_baud_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = c_S_IDLE;
                w_cnt_next   = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    assign rx_busy = (r_state != c_S_IDLE);

endmodule
`default_nettype wire
